// File: rtl/manchester_pkg.sv
// Shared Manchester line-code definitions: decoder FSM states and half-bit pair encodings.
package manchester_pkg;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] PAIR_ONE  = 2'b10;
    localparam logic [1:0] PAIR_ZERO = 2'b01;

    function automatic logic pair_is_valid(input logic [1:0] pair);
        return (pair == PAIR_ONE) || (pair == PAIR_ZERO);
    endfunction

    function automatic logic pair_to_bit(input logic [1:0] pair);
        return (pair == PAIR_ONE);
    endfunction

endpackage

// File: rtl/manchester_pair_sampler.sv
// Registers the line, tracks half-bit phase and emits one decoded pair per two samples.
// An invalid pair keeps phase at the second half so the next pair starts one half-bit later.
module manchester_pair_sampler
    import manchester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic datain,
    output logic pair_stb,
    output logic pair_valid,
    output logic pair_bit
);

    logic       h_reg_r;
    logic       h0_r;
    logic       phase_r;
    logic       stb_r;
    logic       valid_r;
    logic       bit_r;
    logic [1:0] pair_s;
    logic       pair_ok_s;

    // Candidate pair formed from the held first half and the current sample.
    always_comb begin
        pair_s    = {h0_r, h_reg_r};
        pair_ok_s = pair_is_valid(pair_s);
    end

    // Half-bit capture, phase tracking, slip and registered pair decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg_r <= 1'b0;
            h0_r    <= 1'b0;
            phase_r <= 1'b0;
            stb_r   <= 1'b0;
            valid_r <= 1'b0;
            bit_r   <= 1'b0;
        end else if (clr) begin
            h_reg_r <= datain;
            phase_r <= 1'b0;
            stb_r   <= 1'b0;
            valid_r <= 1'b0;
            bit_r   <= 1'b0;
        end else begin
            h_reg_r <= datain;
            if (!phase_r) begin
                h0_r    <= h_reg_r;
                phase_r <= 1'b1;
                stb_r   <= 1'b0;
            end else begin
                stb_r   <= 1'b1;
                valid_r <= pair_ok_s;
                bit_r   <= pair_to_bit(pair_s);
                if (pair_ok_s) begin
                    phase_r <= 1'b0;
                end else begin
                    // Slip: this sample becomes the first half of the next pair.
                    h0_r    <= h_reg_r;
                    phase_r <= 1'b1;
                end
            end
        end
    end

    assign pair_stb   = stb_r;
    assign pair_valid = valid_r;
    assign pair_bit   = bit_r;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester receiver: pair alignment hunt, lock FSM, bit strobes, word deserializer
// and saturating code-error counter.
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_PAIRS = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             datain,
    output logic             dataout,
    output logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             code_err,
    output logic [7:0]       err_cnt
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [3:0]       CNT_LAST = 4'(LOCK_PAIRS - 1);

    logic             pair_stb_s, pair_valid_s, pair_bit_s;
    state_t           state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic             dataout_r, dataout_nxt_s;
    logic             bit_valid_r, bit_valid_nxt_s;
    logic [WIDTH-1:0] word_out_r, word_out_nxt_s;
    logic             word_valid_r, word_valid_nxt_s;
    logic             locked_r, locked_nxt_s;
    logic             code_err_r, code_err_nxt_s;
    logic [7:0]       err_cnt_r, err_cnt_nxt_s;

    manchester_pair_sampler u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (~enable),
        .datain     (datain),
        .pair_stb   (pair_stb_s),
        .pair_valid (pair_valid_s),
        .pair_bit   (pair_bit_s)
    );

    // Next-state, counters, deserializer and output next values.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        idx_nxt_s        = idx_r;
        shreg_nxt_s      = shreg_r;
        dataout_nxt_s    = dataout_r;
        bit_valid_nxt_s  = 1'b0;
        word_out_nxt_s   = word_out_r;
        word_valid_nxt_s = 1'b0;
        code_err_nxt_s   = 1'b0;
        err_cnt_nxt_s    = err_cnt_r;
        if (!enable) begin
            state_nxt_s = ST_HUNT;
            cnt_nxt_s   = 4'd0;
            idx_nxt_s   = {IDX_W{1'b0}};
        end else if (pair_stb_s) begin
            case (state_r)
                ST_HUNT: begin
                    if (pair_valid_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_nxt_s = ST_LOCKED;
                            cnt_nxt_s   = 4'd0;
                        end else begin
                            cnt_nxt_s = cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_nxt_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (pair_valid_s) begin
                        dataout_nxt_s   = pair_bit_s;
                        bit_valid_nxt_s = 1'b1;
                        shreg_nxt_s     = {shreg_r[WIDTH-2:0], pair_bit_s};
                        if (idx_r == IDX_LAST) begin
                            word_out_nxt_s   = shreg_nxt_s;
                            word_valid_nxt_s = 1'b1;
                            idx_nxt_s        = {IDX_W{1'b0}};
                        end else begin
                            idx_nxt_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        code_err_nxt_s = 1'b1;
                        if (err_cnt_r != 8'hFF) begin
                            err_cnt_nxt_s = err_cnt_r + 8'd1;
                        end else begin
                            err_cnt_nxt_s = err_cnt_r;
                        end
                        idx_nxt_s   = {IDX_W{1'b0}};
                        cnt_nxt_s   = 4'd0;
                        state_nxt_s = ST_HUNT;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                    cnt_nxt_s   = 4'd0;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_HUNT;
            cnt_r        <= 4'd0;
            idx_r        <= {IDX_W{1'b0}};
            shreg_r      <= {WIDTH{1'b0}};
            dataout_r    <= 1'b0;
            bit_valid_r  <= 1'b0;
            word_out_r   <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            code_err_r   <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            shreg_r      <= shreg_nxt_s;
            dataout_r    <= dataout_nxt_s;
            bit_valid_r  <= bit_valid_nxt_s;
            word_out_r   <= word_out_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            locked_r     <= locked_nxt_s;
            code_err_r   <= code_err_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
        end
    end

    assign dataout    = dataout_r;
    assign bit_valid  = bit_valid_r;
    assign word_out   = word_out_r;
    assign word_valid = word_valid_r;
    assign locked     = locked_r;
    assign code_err   = code_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_manchester_decoder.sv
// Self-checking bench for manchester_decoder: directed scenarios plus random streams
// compared against a half-bit pointer-walk reference model.
module tb_manchester_decoder;

    localparam int WIDTH      = 8;
    localparam int LOCK_PAIRS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       datain = 1'b0;
    logic       dataout, bit_valid, word_valid, locked, code_err;
    logic [7:0] word_out, err_cnt;

    manchester_decoder #(.WIDTH(WIDTH), .LOCK_PAIRS(LOCK_PAIRS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .datain     (datain),
        .dataout    (dataout),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .code_err   (code_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic       stim[$];
    logic       exp_bits[$];
    logic [7:0] exp_words[$];
    int         exp_errs;
    int         err_model = 0;
    logic       got_bits[$];
    int         bit_cyc[$];
    logic [7:0] got_words[$];
    int         got_errs, overlap, lock_cyc, start_cyc;
    int         cyc = 0;
    logic       locked_q = 1'b0;
    bit         saw_lock;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bit_valid) begin
            got_bits.push_back(dataout);
            bit_cyc.push_back(cyc);
        end
        if (word_valid) got_words.push_back(word_out);
        if (code_err) begin
            got_errs++;
            if (locked) overlap++;
        end
        if (locked) saw_lock = 1'b1;
        if (locked && !locked_q && lock_cyc < 0) lock_cyc = cyc;
        locked_q = locked;
    end

    task automatic put_half(input logic h);
        stim.push_back(h);
    endtask

    task automatic put_bit(input logic b);
        put_half(b);
        put_half(~b);
    endtask

    task automatic put_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
    endtask

    task automatic put_pre();
        for (int i = 0; i < LOCK_PAIRS; i++) put_bit(i % 2 == 0);
    endtask

    task automatic put_pad();
        put_half(1'b0);
        put_half(1'b0);
    endtask

    // Reference: walk the sampled half-bits with a pair pointer. A pair is acted on only if
    // enable is still high when the decoder would process it (start index + 3 < length).
    task automatic model();
        int         n = stim.size();
        int         p = 0;
        bit         lk = 1'b0;
        int         cnt = 0;
        int         nb = 0;
        logic [7:0] sh = 8'd0;
        logic [1:0] pr;
        exp_bits.delete();
        exp_words.delete();
        exp_errs = 0;
        while (p + 3 <= n - 1) begin
            pr = {stim[p], stim[p+1]};
            if (pr == 2'b10 || pr == 2'b01) begin
                if (!lk) begin
                    cnt++;
                    if (cnt == LOCK_PAIRS) begin lk = 1'b1; cnt = 0; end
                end else begin
                    exp_bits.push_back(pr[1]);
                    sh = {sh[6:0], pr[1]};
                    nb++;
                    if (nb == WIDTH) begin exp_words.push_back(sh); nb = 0; end
                end
                p += 2;
            end else begin
                if (lk) begin
                    exp_errs++;
                    if (err_model < 255) err_model++;
                    lk = 1'b0;
                    nb = 0;
                end
                cnt = 0;
                p += 1;
            end
        end
    endtask

    task automatic clear_mon();
        got_bits.delete();
        bit_cyc.delete();
        got_words.delete();
        got_errs = 0;
        overlap = 0;
        lock_cyc = -1;
        saw_lock = 1'b0;
    endtask

    // First half-bit is sampled on an enable-low edge, which fixes pair alignment.
    task automatic play();
        model();
        clear_mon();
        for (int j = 0; j < stim.size(); j++) begin
            @(negedge clk);
            if (j == 0) start_cyc = cyc + 1;
            enable = (j != 0);
            datain = stim[j];
        end
        @(negedge clk);
        enable = 1'b0;
        datain = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", {dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL reset_release got=%h exp=0", {dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt});
        end
        err_model = 0;
    endtask

    task automatic test_aligned();
        stim.delete(); put_pre(); put_byte(8'hA5); put_pad();
        play();
        checks++;
        if (got_words.size() !== 1 || got_words[0] !== 8'hA5) begin
            failures++;
            $display("FAIL aligned_word got_n=%0d got=%h exp=a5", got_words.size(), got_words.size() > 0 ? got_words[0] : 8'h00);
        end
        checks++;
        if (got_bits.size() !== exp_bits.size()) begin
            failures++;
            $display("FAIL aligned_nbits got=%0d exp=%0d", got_bits.size(), exp_bits.size());
        end
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++) begin
            checks++;
            if (got_bits[i] !== exp_bits[i]) begin
                failures++;
                $display("FAIL aligned_bit%0d got=%b exp=%b", i, got_bits[i], exp_bits[i]);
            end
        end
        checks++;
        if (lock_cyc - start_cyc !== 2 + 2 * LOCK_PAIRS - 1) begin
            failures++;
            $display("FAIL aligned_lock_time got=%0d exp=%0d", lock_cyc - start_cyc, 2 + 2 * LOCK_PAIRS - 1);
        end
        checks++;
        if (bit_cyc.size() == 0 || bit_cyc[0] - start_cyc !== 2 + 2 * LOCK_PAIRS + 1) begin
            failures++;
            $display("FAIL aligned_bit_latency got=%0d exp=%0d", bit_cyc.size() > 0 ? bit_cyc[0] - start_cyc : -1, 2 + 2 * LOCK_PAIRS + 1);
        end
        checks++;
        if (got_errs !== 0) begin
            failures++;
            $display("FAIL aligned_code_err got=%0d exp=0", got_errs);
        end
    endtask

    task automatic test_slip();
        stim.delete(); put_half(1'b1); put_pre(); put_byte(8'hA5); put_pad();
        play();
        checks++;
        if (got_words.size() !== 1 || got_words[0] !== 8'hA5) begin
            failures++;
            $display("FAIL slip_word got_n=%0d got=%h exp=a5", got_words.size(), got_words.size() > 0 ? got_words[0] : 8'h00);
        end
        checks++;
        if (lock_cyc - start_cyc !== 2 + 2 * LOCK_PAIRS) begin
            failures++;
            $display("FAIL slip_lock_time got=%0d exp=%0d", lock_cyc - start_cyc, 2 + 2 * LOCK_PAIRS);
        end
        checks++;
        if (got_errs !== 0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL slip_no_err got=%0d/%0d exp=0/0", got_errs, err_cnt);
        end
    endtask

    task automatic test_code_err();
        stim.delete(); put_pre();
        for (int i = 0; i < 3; i++) put_bit(1'($urandom_range(1)));
        put_half(1'b1); put_half(1'b1);
        put_pre(); put_byte(8'h3C); put_pad();
        play();
        checks++;
        if (got_errs !== 1 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL cerr_count pulses=%0d err_cnt=%0d exp=1/1", got_errs, err_cnt);
        end
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL cerr_locked_fall overlap=%0d exp=0", overlap);
        end
        checks++;
        if (got_words.size() !== 1 || got_words[0] !== 8'h3C) begin
            failures++;
            $display("FAIL cerr_word got_n=%0d got=%h exp=3c", got_words.size(), got_words.size() > 0 ? got_words[0] : 8'h00);
        end
        checks++;
        if (err_cnt !== 8'(err_model)) begin
            failures++;
            $display("FAIL cerr_model got=%0d exp=%0d", err_cnt, err_model);
        end
    endtask

    task automatic test_saturate();
        stim.delete();
        for (int i = 0; i < 300; i++) begin
            put_pre(); put_half(1'b1); put_half(1'b1);
        end
        put_pad();
        play();
        checks++;
        if (got_errs !== 300) begin
            failures++;
            $display("FAIL sat_pulses got=%0d exp=300", got_errs);
        end
        checks++;
        if (err_cnt !== 8'hFF || err_cnt !== 8'(err_model)) begin
            failures++;
            $display("FAIL sat_err_cnt got=%h exp=ff model=%0d", err_cnt, err_model);
        end
    endtask

    task automatic test_enable_drop();
        stim.delete(); put_pre();
        for (int i = 0; i < 5; i++) put_bit(1'($urandom_range(1)));
        put_pad();
        play();
        checks++;
        if (saw_lock !== 1'b1 || locked !== 1'b0 || got_bits.size() !== 5 || got_words.size() !== 0) begin
            failures++;
            $display("FAIL en_drop lock_seen=%b locked=%b bits=%0d words=%0d exp=1/0/5/0", saw_lock, locked, got_bits.size(), got_words.size());
        end
        stim.delete(); put_pre(); put_byte(8'h81); put_pad();
        play();
        checks++;
        if (got_words.size() !== 1 || got_words[0] !== 8'h81) begin
            failures++;
            $display("FAIL en_word got_n=%0d got=%h exp=81", got_words.size(), got_words.size() > 0 ? got_words[0] : 8'h00);
        end
        checks++;
        if (err_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL en_err_hold got=%h exp=ff", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        stim.delete(); put_pre(); put_byte(8'h5A);
        clear_mon();
        for (int j = 0; j < 2 * LOCK_PAIRS + 10; j++) begin
            @(negedge clk);
            enable = (j != 0);
            datain = stim[j];
        end
        @(negedge clk);
        #2;
        checks++;
        if (locked !== 1'b1 || got_bits.size() == 0) begin
            failures++;
            $display("FAIL rmid_pre locked=%b bits=%0d exp=1/>0", locked, got_bits.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=0", {dataout, bit_valid, word_out, word_valid, locked, code_err, err_cnt});
        end
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b1;
        err_model = 0;
        checks++;
        if (got_words.size() !== 0) begin
            failures++;
            $display("FAIL rmid_no_word got=%0d exp=0", got_words.size());
        end
        stim.delete(); put_pre(); put_byte(8'h5A); put_pad();
        play();
        checks++;
        if (got_words.size() !== 1 || got_words[0] !== 8'h5A || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rmid_word got_n=%0d got=%h err=%0d exp=5a/0", got_words.size(), got_words.size() > 0 ? got_words[0] : 8'h00, err_cnt);
        end
    endtask

    task automatic test_random();
        int nbytes, pos;
        for (int it = 0; it < 24; it++) begin
            stim.delete();
            if ($urandom_range(1) == 1) put_half(1'($urandom_range(1)));
            put_pre();
            nbytes = $urandom_range(3, 1);
            for (int b = 0; b < nbytes; b++) put_byte(8'($urandom));
            if ($urandom_range(2) == 0) begin
                pos = $urandom_range(stim.size() - 1, 2 * LOCK_PAIRS);
                stim[pos] = ~stim[pos];
            end
            put_pad();
            play();
            checks++;
            if (got_bits.size() !== exp_bits.size()) begin
                failures++;
                $display("FAIL rnd%0d_nbits got=%0d exp=%0d", it, got_bits.size(), exp_bits.size());
            end
            for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++) begin
                checks++;
                if (got_bits[i] !== exp_bits[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_bit%0d got=%b exp=%b", it, i, got_bits[i], exp_bits[i]);
                end
            end
            checks++;
            if (got_words.size() !== exp_words.size()) begin
                failures++;
                $display("FAIL rnd%0d_nwords got=%0d exp=%0d", it, got_words.size(), exp_words.size());
            end
            for (int i = 0; i < exp_words.size() && i < got_words.size(); i++) begin
                checks++;
                if (got_words[i] !== exp_words[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_word%0d got=%h exp=%h", it, i, got_words[i], exp_words[i]);
                end
            end
            checks++;
            if (got_errs !== exp_errs || err_cnt !== 8'(err_model)) begin
                failures++;
                $display("FAIL rnd%0d_errs pulses=%0d err_cnt=%0d exp=%0d/%0d", it, got_errs, err_cnt, exp_errs, err_model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_slip();
        test_code_err();
        test_saturate();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
